btn_debounce: RTL
=================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 The block SHALL take parameter N_BTN, default 2, as the number of independent button channels (select, set).
REQ-002 The block SHALL take parameter DEBOUNCE_CYCLES, default 1000000, as the number of stable-input cycles required before a level change is accepted; legal range is ≥2.
REQ-003 The block SHALL take parameters REPEAT_DELAY, default 50000000, and REPEAT_PERIOD, default 10000000, as auto-repeat timing in cycles; both are used only under REQ-022.
REQ-004 The block SHALL have port clk, input, 1 bit, as the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit, as the reset; reset is synchronous and active-high.
REQ-006 The block SHALL have port i_btn, input, N_BTN bits, carrying raw asynchronous bouncing button levels (1 = pressed).
REQ-007 The block SHALL have port o_btn_level, output, N_BTN bits, carrying the debounced level per channel.
REQ-008 The block SHALL have port o_btn_pulse, output, N_BTN bits, carrying a one-cycle press strobe per channel that feeds btn_select/btn_set of the operand-capture stage.

Function
REQ-009 Each channel SHALL pass i_btn through a 2-flop synchronizer before any other use.
REQ-010 Each channel SHALL implement the FSM S_RELEASED, S_PRESS_WAIT, S_PRESSED, S_RELEASE_WAIT, with o_btn_level=1 only in S_PRESSED and S_RELEASE_WAIT.
REQ-011 S_RELEASED SHALL move to S_PRESS_WAIT, clearing the counter, when the synced input is 1.
REQ-012 S_PRESS_WAIT SHALL return to S_RELEASED when the synced input is 0 (bounce).
REQ-013 S_PRESS_WAIT SHALL move to S_PRESSED when the counter equals DEBOUNCE_CYCLES-1 and the synced input is 1; otherwise the counter increments.
REQ-014 S_PRESSED SHALL move to S_RELEASE_WAIT, clearing the counter, when the synced input is 0.
REQ-015 S_RELEASE_WAIT SHALL return to S_PRESSED on synced input 1 without a pulse, and SHALL move to S_RELEASED when the counter reaches DEBOUNCE_CYCLES-1 with the input still 0.
REQ-016 o_btn_pulse[i] SHALL be registered and SHALL be high for exactly the one cycle in which channel i first enters S_PRESSED from S_PRESS_WAIT.
REQ-017 The press latency SHALL be exact: if edge k is the first edge to sample i_btn[i]=1 and the input stays stable, o_btn_pulse[i] SHALL go high after edge k+DEBOUNCE_CYCLES+2.
REQ-018 No release event SHALL produce a pulse.
REQ-019 Channels SHALL be fully independent, and simultaneous pulses on several channels in the same cycle are legal.
REQ-020 The counter width SHALL be $clog2 of the largest used count; the counter SHALL never wrap, because it is held or cleared on every transition.

Reset
REQ-021 While i_reset=1 at a clock edge, all synchronizer flops, counters and outputs SHALL go to 0 and all FSMs to S_RELEASED; a button held through reset SHALL require a full fresh debounce (REQ-017 latency, counted from the first edge after reset deasserts) before pulsing, and a pulse in flight SHALL be suppressed.

Configuration
REQ-022 When BTN_AUTOREPEAT_EN is defined, each channel held in S_PRESSED SHALL emit additional one-cycle pulses REPEAT_DELAY cycles after the initial pulse and then every REPEAT_PERIOD cycles. Leaving S_PRESSED SHALL clear the repeat counter. Without the macro, there is no repeat logic and exactly one pulse is emitted per press.

Structure
REQ-023 The FSM state encoding (2-bit enum) and the synchronizer depth constant (2) SHALL live in shared package btn_pkg.
REQ-024 Per-channel logic SHALL be sub-module btn_debounce_ch, instantiated N_BTN times by a generate loop. The top level SHALL contain only wiring.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-025 Clean press: i_btn[0] 0->1 sampled at edge 0 and held -> o_btn_pulse[0]=1 for one cycle after edge 6, o_btn_level[0]=1 from edge 6 on, channel 1 stays 0.
REQ-026 Bounce: i_btn[0]=1 for 2 cycles, 0 for 1 cycle, then 1 held -> no pulse before the restart, then a single pulse 6 edges after the final rising sample.
REQ-027 Release bounce: while pressed, drop i_btn for 2 cycles then restore -> o_btn_level stays 1 and no pulse; a sustained release -> level 0 after 6 edges and no pulse.
REQ-028 Simultaneous: both buttons rise at the same edge -> both pulses in the same cycle.
REQ-029 Reset mid-debounce: assert i_reset at edge 3 of a press and hold the button -> no pulse at edge 6; the pulse appears 6 edges after reset deasserts.
REQ-030 Auto-repeat, with BTN_AUTOREPEAT_EN: hold for 20 cycles after the first pulse -> pulses at +0, +8, +11, +14, +17; without the macro only the +0 pulse occurs.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and constants for the button debouncer.
package btn_pkg;

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int SYNC_STAGES = 2;

    // Bits needed to hold counts 0..max_count-1, never less than one.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounced button channel: synchronizer, press/release FSM, press strobe.
// Auto-repeat strobes are added when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_btn_level,
    output logic o_btn_pulse
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("btn_debounce_ch: repeat timing must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    btn_state_t             state;
    logic [CW-1:0]          cnt;
    logic                   pulse_q;
    logic                   rep_hit;

    always_ff @(posedge clk) begin
        if (i_reset) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], i_btn};
    end

    assign btn_s = sync_q[SYNC_STAGES-1];

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = cnt_width(REP_MAX);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_phase;  // 0: waiting out the initial delay, 1: periodic

    assign rep_hit = (state == S_PRESSED) && btn_s &&
                     (rep_cnt == (rep_phase ? PER_LAST : DLY_LAST));

    always_ff @(posedge clk) begin
        if (i_reset || state != S_PRESSED || !btn_s) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (rep_hit) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b1;
        end else begin
            rep_cnt   <= rep_cnt + RW'(1);
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state   <= S_RELEASED;
            cnt     <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state)
                S_RELEASED: begin
                    if (btn_s) begin
                        state <= S_PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= S_RELEASED;
                    end else if (cnt == CNT_LAST) begin
                        state   <= S_PRESSED;
                        pulse_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_PRESSED: begin
                    if (!btn_s) begin
                        state <= S_RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (rep_hit) begin
                        pulse_q <= 1'b1;
                    end
                end
                S_RELEASE_WAIT: begin
                    // A short dip returns to PRESSED silently; only a full debounce releases.
                    if (btn_s) begin
                        state <= S_PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_RELEASED;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_RELEASED;
            endcase
        end
    end

    assign o_btn_level = (state == S_PRESSED) || (state == S_RELEASE_WAIT);
    assign o_btn_pulse = pulse_q;

endmodule

// File: rtl/btn_debounce.sv
// Array of independent debounced button channels.
// Optional auto-repeat: define BTN_AUTOREPEAT_EN.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_btn_level,
    output logic [N_BTN-1:0] o_btn_pulse
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .i_reset     (i_reset),
            .i_btn       (i_btn[g]),
            .o_btn_level (o_btn_level[g]),
            .o_btn_pulse (o_btn_pulse[g])
        );
    end

endmodule
